// File: rtl/indicator_sequencer_if.sv
// rtl/indicator_sequencer_if.sv - request inputs and lamp outputs of the tail-light sequencer
interface indicator_sequencer_if;
    logic       left;
    logic       right;
    logic       hazard;
    logic       brake;
    logic [5:0] TailLights;
    logic       busy;

    modport master (
        output left, right, hazard, brake,
        input  TailLights, busy
    );

    modport slave (
        input  left, right, hazard, brake,
        output TailLights, busy
    );
endinterface

// File: rtl/indicator_sequencer.sv
// rtl/indicator_sequencer.sv - arbitrated, prescaled Thunderbird tail-light sequencer
module indicator_sequencer #(
    parameter  int TICK_DIV = 4,
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    indicator_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        L1   = 4'd1,
        L2   = 4'd2,
        L3   = 4'd3,
        R1   = 4'd4,
        R2   = 4'd5,
        R3   = 4'd6,
        HON  = 4'd7,
        GAP  = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             brake_q, brake_d;
    logic [5:0]       lights_q, lights_d;
    logic             busy_q, busy_d;
    logic             tick;
    logic [CNT_W-1:0] presc_step;

    // Lamp pattern for a given state; brake fills the idle cluster, HON is always all-on.
    function automatic logic [5:0] decode(input state_t s, input logic brk);
        logic [2:0] fill;
        fill = brk ? 3'b111 : 3'b000;
        case (s)
            L1:      decode = {3'b001, fill};
            L2:      decode = {3'b011, fill};
            L3:      decode = {3'b111, fill};
            R1:      decode = {fill, 3'b100};
            R2:      decode = {fill, 3'b110};
            R3:      decode = {fill, 3'b111};
            HON:     decode = 6'b111111;
            default: decode = {fill, fill};
        endcase
    endfunction

    // Next-state arbitration, prescaler pacing and registered-output precompute.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        tick       = (presc_q == TICK_LAST);
        presc_step = tick ? '0 : presc_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                presc_d = '0;
                if (bus.hazard || (bus.left && bus.right)) begin
                    state_d = HON;
                end else if (bus.left) begin
                    state_d = L1;
                end else if (bus.right) begin
                    state_d = R1;
                end
            end
            L1, L2, L3, R1, R2, R3: begin
                presc_d = presc_step;
                if (tick) begin
                    if (bus.hazard) begin
                        state_d = HON;
                    end else begin
                        case (state_q)
                            L1:      state_d = L2;
                            L2:      state_d = L3;
                            R1:      state_d = R2;
                            R2:      state_d = R3;
                            default: state_d = GAP;
                        endcase
                    end
                end
            end
            HON: begin
                presc_d = presc_step;
                if (tick) state_d = GAP;
            end
            GAP: begin
                presc_d = presc_step;
                if (tick) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
            end
        endcase
        brake_d  = bus.brake;
        lights_d = decode(state_d, brake_d);
        busy_d   = (state_d != IDLE);
    end

    // All state, including the lamp drive, updates here; reset aborts any sequence at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            brake_q  <= 1'b0;
            lights_q <= 6'b000000;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            brake_q  <= brake_d;
            lights_q <= lights_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.TailLights = lights_q;
    assign bus.busy       = busy_q;

endmodule

// File: doc/indicator_sequencer.md
Name: indicator_sequencer

Overview:
- Top-level Thunderbird tail-light controller. Arbitrates raw left, right, hazard and brake requests and paces lamp steps with a clock prescaler.
- Drives the 6-bit tail-light bus: TailLights[5:3] is the left cluster, TailLights[2:0] is the right cluster.
- Cluster codes are fixed:
  - Left sequence: 001000, 011000, 111000.
  - Right sequence: 000100, 000110, 000111.
- Replaces the free-running one-step-per-clock indicator with a scheduled, arbitrated one.

Parameters:
TICK_DIV, 4, clock cycles per lamp step (legal range >= 1; 1 means one step per clock)
CNT_W, $clog2(TICK_DIV) (minimum 1), prescaler counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; one clock: one clock, synchronous active-high reset
left  input  1  left-turn request, level
right  input  1  right-turn request, level
hazard  input  1  hazard request, level
brake  input  1  brake pedal, level
TailLights  output  6  lamp drive, 1 = lamp on
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (sampled at clk edge):
  - state=IDLE, prescaler=0, brake_q=0.
  - TailLights=000000, busy=0 from the following edge.
  - Reset mid-sequence aborts immediately; no completion of the sequence.
- States: IDLE, L1, L2, L3, R1, R2, R3, HON, GAP.
- Prescaler:
  - Cleared on every transition out of IDLE.
  - Otherwise counts 0..TICK_DIV-1 and wraps.
  - tick = (prescaler == TICK_DIV-1).
  - In IDLE, prescaler is held at 0.
- IDLE request priority, evaluated every clock:
  1. hazard=1, or left=1 and right=1 -> HON.
  2. Else left only -> L1.
  3. Else right only -> R1.
  4. Else stay in IDLE.
- Non-IDLE transitions occur only on tick:
  - L1->L2->L3->GAP.
  - R1->R2->R3->GAP.
  - HON->GAP.
  - GAP->IDLE.
  - Each state therefore lasts exactly TICK_DIV cycles.
- Turn requests are latched by the sequence:
  - Deasserting left/right mid-sequence does not shorten it.
  - The opposite turn request is ignored until IDLE.
- Hazard preemption:
  - hazard=1 at a tick edge while in L1..L3 or R1..R3 -> HON (abort).
  - Hazard seen between ticks has no effect unless it is still high at the tick.
- Repetition:
  - A held request repeats with period 4*TICK_DIV+1 cycles for turns (3 steps + GAP + 1 IDLE cycle).
  - Period is 2*TICK_DIV+1 cycles for hazard.
- brake_q is brake registered every clock, giving 1-cycle brake latency.
- Decode (combinational from state and brake_q; output changes only at clock edges):
  - IDLE/GAP: 000000, or 111111 if brake_q.
  - L1/L2/L3: left code in [5:3]; [2:0] = 111 if brake_q, else 000.
  - R1/R2/R3: right code in [2:0]; [5:3] = 111 if brake_q, else 000.
  - HON: 111111 regardless of brake_q.
- Illegal state encoding: go to IDLE on the next clock; outputs decode as IDLE.

Test Plan:
- TICK_DIV=4; reset for 2 cycles, then left=1 for 1 cycle at edge E0 -> TailLights as follows, busy=1 over E0..E15:
  - 001000 from E0.
  - 011000 at E4.
  - 111000 at E8.
  - 000000 (GAP) at E12.
  - IDLE at E16.
- right held high continuously -> 000100/000110/000111/000000 steps, repeating every 17 cycles; left pulsed during R2 -> no effect.
- left+right together in IDLE -> 111111 for 4 cycles, then 000000 for 4 cycles, repeating every 9 cycles while held.
- Hazard during L2, rising 2 cycles before the tick -> L2 held until the tick, then 111111 (HON), then GAP, then IDLE.
- brake=1 during R1 -> one cycle later TailLights=111100; brake=1 in IDLE -> 111111 one cycle later; release -> 000000 one cycle later.
- reset=1 during L3 with TICK_DIV=1 -> next edge TailLights=000000, busy=0; then left=1 -> L1 on the following edge, stepping every clock.
